// File: rtl/spatial_shift_acc_if.sv
// spatial_shift_acc_if: beat input and result output valid/ready bundle for spatial_shift_acc.
interface spatial_shift_acc_if #(
   parameter int PP_WIDTH    = 5,
   parameter int SHIFT_WIDTH = 4,
   parameter int ACC_WIDTH   = 32
);
   logic                   in_valid;
   logic                   in_ready;
   logic [PP_WIDTH-1:0]    in_pp;
   logic [SHIFT_WIDTH-1:0] in_shift;
   logic                   in_first;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [ACC_WIDTH-1:0]   out_data;
   logic                   out_ovf;
   modport master (
      output in_valid, in_pp, in_shift, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );
   modport slave (
      input  in_valid, in_pp, in_shift, in_first, in_last, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/spatial_shift_acc.sv
// spatial_shift_acc: accumulates sign-extended partial products shifted left per beat into one result per first..last run.
// Define SPATIAL_SHIFT_ACC_SAT_EN for saturating adds with a sticky out_ovf flag; default build wraps.
module spatial_shift_acc #(
   parameter int PP_WIDTH    = 5,
   parameter int SHIFT_WIDTH = 4,
   parameter int ACC_WIDTH   = 32
) (
   input logic                clk,
   input logic                reset,
   spatial_shift_acc_if.slave bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;
   logic [0:0]             state;
   logic [SHIFT_WIDTH-1:0] shift;
   logic [ACC_WIDTH-1:0]   acc, term, base, sum;
   logic                   fire, start;
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign fire  = bus.in_valid && bus.in_ready;
   assign start = state == IDLE || bus.in_first;
   assign shift = bus.in_shift;
   // shifts of ACC_WIDTH or more push every bit out, giving a zero term
   assign term  = {{(ACC_WIDTH-PP_WIDTH){bus.in_pp[PP_WIDTH-1]}}, bus.in_pp} << shift;
   assign base  = start ? '0 : acc;
`ifdef SPATIAL_SHIFT_ACC_SAT_EN
   logic [ACC_WIDTH:0] wide;
   logic               clamp, sticky, sticky_nxt;
   assign wide       = {base[ACC_WIDTH-1], base} + {term[ACC_WIDTH-1], term};
   assign clamp      = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
   assign sum        = clamp ? {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}} : wide[ACC_WIDTH-1:0];
   assign sticky_nxt = (!start && sticky) || clamp;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky      <= 1'b0;
         bus.out_ovf <= 1'b0;
      end else if (fire && bus.in_last) begin
         sticky      <= 1'b0;
         bus.out_ovf <= sticky_nxt;
      end else if (fire) begin
         sticky      <= sticky_nxt;
      end
   end
`else
   assign sum         = base + term;
   assign bus.out_ovf = 1'b0;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         acc           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else if (fire && bus.in_last) begin
         state         <= IDLE;
         acc           <= '0;
         bus.out_valid <= 1'b1;
         bus.out_data  <= sum;
      end else begin
         if (fire) begin
            state <= ACCUM;
            acc   <= sum;
         end
         if (bus.out_ready) bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_spatial_shift_acc.sv
// tb_spatial_shift_acc: directed vector table on a 32-bit instance plus hand sequences for stall,
// reset and 8-bit wrap/saturation corners (expectations follow SPATIAL_SHIFT_ACC_SAT_EN).
module tb_spatial_shift_acc;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   spatial_shift_acc_if #(.PP_WIDTH(5), .SHIFT_WIDTH(4), .ACC_WIDTH(32)) bus ();
   spatial_shift_acc_if #(.PP_WIDTH(5), .SHIFT_WIDTH(4), .ACC_WIDTH(8))  bus8 ();
   spatial_shift_acc #(.PP_WIDTH(5), .SHIFT_WIDTH(4), .ACC_WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
   spatial_shift_acc #(.PP_WIDTH(5), .SHIFT_WIDTH(4), .ACC_WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));
`ifdef SPATIAL_SHIFT_ACC_SAT_EN
   localparam logic [7:0] POS_EXP = 8'h7F;
   localparam logic [7:0] NEG_EXP = 8'h80;
   localparam logic       OVF_EXP = 1'b1;
`else
   localparam logic [7:0] POS_EXP = 8'h87;
   localparam logic [7:0] NEG_EXP = 8'h7F;
   localparam logic       OVF_EXP = 1'b0;
`endif
   typedef struct {
      logic        v;
      logic [4:0]  pp;
      logic [3:0]  sh;
      logic        f, l, ordy, ev;
      logic [31:0] ed;
   } vec_t;
   vec_t tbl[18];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   task automatic put(input logic v, input logic [4:0] pp, input logic [3:0] sh,
                      input logic f, input logic l, input logic ordy);
      bus.in_valid = v; bus.in_pp = pp; bus.in_shift = sh;
      bus.in_first = f; bus.in_last = l; bus.out_ready = ordy;
   endtask
   task automatic put8(input logic v, input logic [4:0] pp, input logic [3:0] sh,
                       input logic f, input logic l, input logic ordy);
      bus8.in_valid = v; bus8.in_pp = pp; bus8.in_shift = sh;
      bus8.in_first = f; bus8.in_last = l; bus8.out_ready = ordy;
   endtask
   initial begin
      tbl[0]  = '{1'b1, 5'h1D, 4'd2,  1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFF4};
      tbl[1]  = '{1'b1, 5'h03, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF4};
      tbl[2]  = '{1'b1, 5'h1E, 4'd2,  1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFB};
      tbl[3]  = '{1'b0, 5'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFB};
      tbl[4]  = '{1'b1, 5'h05, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFB};
      tbl[5]  = '{1'b1, 5'h07, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFB};
      tbl[6]  = '{1'b1, 5'h01, 4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFB};
      tbl[7]  = '{1'b1, 5'h01, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h00000003};
      tbl[8]  = '{1'b0, 5'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00000003};
      tbl[9]  = '{1'b1, 5'h01, 4'd4,  1'b1, 1'b1, 1'b1, 1'b1, 32'h00000010};
      tbl[10] = '{1'b1, 5'h1F, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
      tbl[11] = '{1'b1, 5'h10, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFF80000};
      tbl[12] = '{1'b0, 5'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFF80000};
      tbl[13] = '{1'b1, 5'h04, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFF80000};
      tbl[14] = '{1'b1, 5'h02, 4'd1,  1'b0, 1'b1, 1'b1, 1'b1, 32'h00000008};
      tbl[15] = '{1'b0, 5'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00000008};
      tbl[16] = '{1'b1, 5'h0F, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00078000};
      tbl[17] = '{1'b0, 5'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h00078000};
      reset = 1'b1;
      put(0, 0, 0, 0, 0, 0);
      put8(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_data", bus.out_data, 32'd0);
      chk("reset_ovf", {31'd0, bus.out_ovf}, 32'd0);
      chk("reset_ready", {31'd0, bus.in_ready}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 18; i++) begin
         put(tbl[i].v, tbl[i].pp, tbl[i].sh, tbl[i].f, tbl[i].l, tbl[i].ordy);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
         chk($sformatf("vec%0d_data", i), bus.out_data, tbl[i].ed);
         chk($sformatf("vec%0d_ovf", i), {31'd0, bus.out_ovf}, 32'd0);
      end
      // held result under backpressure, then back-to-back replacement
      put(1, 5'h06, 0, 1, 1, 0);
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_data", bus.out_data, 32'd6);
      put(1, 5'h07, 0, 1, 1, 0);
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("stall%0d_ready", k), {31'd0, bus.in_ready}, 32'd0);
         @(negedge clk);
         chk($sformatf("stall%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
         chk($sformatf("stall%0d_data", k), bus.out_data, 32'd6);
      end
      put(1, 5'h07, 0, 1, 1, 1);
      #1 chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("b2b_data", bus.out_data, 32'd7);
      put(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("b2b_drain", {31'd0, bus.out_valid}, 32'd0);
      // 8-bit instance: wrap or saturate depending on build
      put8(1, 5'h0F, 4'd3, 1, 0, 1);
      @(negedge clk);
      put8(1, 5'h0F, 4'd0, 0, 1, 1);
      @(negedge clk);
      chk("w8_pos_data", {24'd0, bus8.out_data}, {24'd0, POS_EXP});
      chk("w8_pos_ovf", {31'd0, bus8.out_ovf}, {31'd0, OVF_EXP});
      put8(1, 5'h03, 4'd15, 1, 1, 1);
      @(negedge clk);
      chk("w8_shift15_data", {24'd0, bus8.out_data}, 32'd0);
      chk("w8_shift15_ovf", {31'd0, bus8.out_ovf}, 32'd0);
      put8(1, 5'h10, 4'd3, 1, 0, 1);
      @(negedge clk);
      put8(1, 5'h1F, 4'd0, 0, 1, 1);
      @(negedge clk);
      chk("w8_neg_data", {24'd0, bus8.out_data}, {24'd0, NEG_EXP});
      chk("w8_neg_ovf", {31'd0, bus8.out_ovf}, {31'd0, OVF_EXP});
      put8(1, 5'h01, 4'd0, 1, 1, 1);
      @(negedge clk);
      chk("w8_clear_data", {24'd0, bus8.out_data}, 32'd1);
      chk("w8_clear_ovf", {31'd0, bus8.out_ovf}, 32'd0);
      put8(0, 0, 0, 0, 0, 1);
      // async reset mid-accumulation discards the partial sum
      put(1, 5'h05, 0, 1, 0, 1);
      @(negedge clk);
      put(0, 0, 0, 0, 0, 1);
      #2 reset = 1'b1;
      #1 chk("rst_mid_data", bus.out_data, 32'd0);
      chk("rst_mid_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      put(1, 5'h02, 0, 0, 1, 0);
      @(negedge clk);
      chk("rst_after_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("rst_after_data", bus.out_data, 32'd2);
      put(0, 0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1 chk("rst_held_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_held_data", bus.out_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
